// File: rtl/reg_wr_arbiter.sv
// Arbitrated register file: N_REQ writers share DEPTH enable-gated registers.
// Round-robin grant with optional locked bursts of up to LOCK_MAX beats.
module reg_wr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int DEPTH    = 4,
  parameter int LOCK_MAX = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BW = $clog2(LOCK_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic [DEPTH-1:0]    wr_en,
  output logic [GW-1:0]       grant_id,
  output logic                locked
);

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [GW-1:0]    owner_q, owner_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [DEPTH-1:0] wr_en_q;
  logic [GW-1:0]    grant_q;
  logic [DW-1:0]    regs_q [DEPTH];

  logic [N_REQ-1:0] arb_ready;
  logic [N_REQ-1:0] own_ready;
  logic             found;
  logic [GW-1:0]    idx;
  logic [GW-1:0]    g;
  logic             fire;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [DEPTH-1:0] we;

  function automatic logic [GW-1:0] nxt(input logic [GW-1:0] x);
    return GW'((int'(x) + 1) % N_REQ);
  endfunction

  // First valid requester at or above ptr, wrapping.
  always_comb begin
    arb_ready = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = GW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found          = 1'b1;
        arb_ready[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    own_ready          = '0;
    own_ready[owner_q] = req_valid[owner_q];
  end

  always_comb begin
    req_ready = '0;
    if (reset) begin
      if (state_q == ST_LOCKED) req_ready = own_ready;
      else                      req_ready = arb_ready;
    end
  end

  assign fire = |req_ready;

  always_comb begin
    g        = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        g        = GW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Out-of-range addresses match no register and are dropped.
  always_comb begin
    we = '0;
    for (int r = 0; r < DEPTH; r++) begin
      we[r] = fire && (int'(sel_addr) == r);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_ARB: begin
        if (fire) begin
          ptr_d = nxt(g);
          if (req_lock[g] && LOCK_MAX > 1) begin
            state_d = ST_LOCKED;
            owner_d = g;
            beat_d  = BW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!req_valid[owner_q]) begin
          state_d = ST_ARB;
          ptr_d   = nxt(owner_q);
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
          if (!req_lock[owner_q] || beat_d == BW'(LOCK_MAX)) begin
            state_d = ST_ARB;
            ptr_d   = nxt(owner_q);
            beat_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      beat_q  <= '0;
      wr_en_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      wr_en_q <= we;
      if (fire) grant_q <= g;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (we[r]) regs_q[r] <= sel_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (int'(rd_addr) == r) rd_data = regs_q[r];
    end
  end

  assign wr_en    = wr_en_q;
  assign grant_id = grant_q;
  assign locked   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: transaction-level model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_reg_wr_arbiter;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int GW    = 2;
  localparam int LM    = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rd_addr = '0;
  logic [DW-1:0]   rd_data;
  logic [DEPTH-1:0] wr_en;
  logic [GW-1:0]   grant_id;
  logic            locked;

  int n_chk = 0;
  int n_fail = 0;

  reg_wr_arbiter #(
    .N_REQ(N), .DW(DW), .DEPTH(DEPTH), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: register contents, rotation pointer, burst ownership.
  logic [DW-1:0]    m_regs [DEPTH];
  int               m_ptr = 0;
  int               m_owner = 0;
  int               m_beats = 0;
  int               m_gid = 0;
  bit               m_locked = 1'b0;
  logic [DEPTH-1:0] m_wr = '0;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (!reset) return r;
    if (m_locked) begin
      if (req_valid[m_owner]) r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [N-1:0] r;
    int g;
    int a;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_ptr = 0; m_owner = 0; m_beats = 0;
      m_gid = 0; m_locked = 1'b0; m_wr = '0;
    end else begin
      r = exp_ready();
      m_wr = '0;
      if (r != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        a = int'(req_addr[g*AW +: AW]);
        if (a < DEPTH) begin
          m_regs[a] = req_data[g*DW +: DW];
          m_wr[a] = 1'b1;
        end
        m_gid = g;
        if (!m_locked) begin
          m_ptr = (g + 1) % N;
          if (req_lock[g]) begin
            m_locked = 1'b1;
            m_owner = g;
            m_beats = 1;
          end
        end else begin
          m_beats++;
          if (!req_lock[g] || m_beats == LM) begin
            m_locked = 1'b0;
            m_ptr = (g + 1) % N;
          end
        end
      end else if (m_locked) begin
        m_locked = 1'b0;
        m_ptr = (m_owner + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", req_ready, exp_ready());
    chk("wr_en", wr_en, m_wr);
    chk("grant_id", grant_id, m_gid);
    chk("locked", locked, m_locked);
    chk("rd_data", rd_data, m_regs[rd_addr]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  int exp_rr [5] = '{0, 1, 2, 3, 0};

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_rd", rd_data, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < N; i++) set_req(i, i, 8'h10 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gid", grant_id, exp_rr[k]);
      chk("rr_wr", wr_en, 1 << exp_rr[k]);
    end
    req_valid = '0;
    tick();

    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1, 8'h30 + k);
      tick();
      chk("lock_gid", grant_id, 1);
      chk("lock_flag", locked, (k < 3) ? 1 : 0);
    end
    tick();
    chk("lock_next_gid", grant_id, 2);
    chk("lock_next_wr", wr_en, 4'b0100);
    req_valid = '0;
    req_lock  = '0;
    tick();

    req_valid = 4'b1001;
    req_lock  = 4'b1000;
    tick();
    chk("early_gid", grant_id, 3);
    chk("early_lock", locked, 1);
    req_valid = 4'b0001;
    #1 chk("early_stall", req_ready, 0);
    tick();
    chk("early_unlock", locked, 0);
    chk("early_nowr", wr_en, 0);
    tick();
    chk("early_gid0", grant_id, 0);
    chk("early_wr0", wr_en, 4'b0001);
    req_valid = '0;
    req_lock  = '0;
    tick();

    set_req(0, 2, 8'hA5);
    rd_addr = 2'd2;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("hold_wr", wr_en, 4'b0100);
    chk("hold_rd", rd_data, 8'hA5);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_idle_wr", wr_en, 0);
      chk("hold_idle_rd", rd_data, 8'hA5);
    end

    set_req(0, 1, 8'h11);
    set_req(2, 1, 8'h22);
    rd_addr = 2'd1;
    req_valid = 4'b0001;
    tick();
    chk("col_wr1", wr_en, 4'b0010);
    chk("col_rd1", rd_data, 8'h11);
    req_valid = 4'b0100;
    tick();
    chk("col_wr2", wr_en, 4'b0010);
    chk("col_rd2", rd_data, 8'h22);
    req_valid = '0;
    tick();
    chk("col_idle", wr_en, 0);

    set_req(1, 3, 8'h77);
    req_valid = 4'b0010;
    req_lock  = 4'b0010;
    tick();
    chk("rl_lock", locked, 1);
    chk("rl_gid", grant_id, 1);
    set_req(1, 3, 8'h99);
    #2 reset = 1'b0;
    #1;
    chk("rl_ready", req_ready, 0);
    chk("rl_wr", wr_en, 0);
    chk("rl_gid0", grant_id, 0);
    chk("rl_locked", locked, 0);
    chk("rl_rd1", rd_data, 0);
    rd_addr = 2'd3;
    #1 chk("rl_rd3", rd_data, 0);
    tick();
    chk("rl_hold_rd3", rd_data, 0);
    reset = 1'b1;
    req_lock = '0;
    req_valid = 4'b1010;
    tick();
    chk("rl_first", grant_id, 1);
    chk("rl_first_wr", wr_en, 4'b1000);
    tick();
    chk("rl_second", grant_id, 3);
    req_valid = '0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of write requesters.
REQ-002 The block SHALL have parameter DW, default 8, register data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of enable-gated registers; AW = clog2(DEPTH).
REQ-004 The block SHALL have parameter LOCK_MAX, default 4, maximum consecutive beats per locked burst.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, N_REQ, per-requester write request.
REQ-008 The block SHALL have port req_lock, input, N_REQ, per-requester request to keep the grant after this beat.
REQ-009 The block SHALL have port req_addr, input, N_REQ*AW, packed per-requester target register; requester i occupies bits [i*AW +: AW].
REQ-010 The block SHALL have port req_data, input, N_REQ*DW, packed per-requester write data; requester i occupies bits [i*DW +: DW].
REQ-011 The block SHALL have port req_ready, output, N_REQ, one-hot grant, combinational.
REQ-012 The block SHALL have port rd_addr, input, AW, read select.
REQ-013 The block SHALL have port rd_data, output, DW, combinational read of register rd_addr.
REQ-014 The block SHALL have port wr_en, output, DEPTH, registered one-hot pulse marking the register written on the previous edge.
REQ-015 The block SHALL have port grant_id, output, clog2(N_REQ), registered index of the last accepted requester.
REQ-016 The block SHALL have port locked, output, 1, high while in LOCKED state.

Function
REQ-017 A beat SHALL transfer on a rising edge where req_valid[i] and req_ready[i] are both high; at most one beat per cycle.
REQ-018 req_ready SHALL depend only on req_valid, state, owner and priority pointer, never on req_addr or req_data; req_ready SHALL be all-zero when req_valid is all-zero.
REQ-019 FSM states SHALL be ARB and LOCKED; reset state ARB.
REQ-020 In ARB, the grant SHALL go to the first valid requester searching from priority pointer ptr upward, modulo N_REQ.
REQ-021 After each transfer by requester g in ARB, ptr SHALL become (g+1) mod N_REQ.
REQ-022 ARB->LOCKED SHALL occur on a transfer with req_lock[g]=1; owner<=g; beat counter<=1.
REQ-023 In LOCKED, req_ready SHALL be asserted only for owner, and only while req_valid[owner]=1; other requesters SHALL stall.
REQ-024 In LOCKED, each owner transfer SHALL increment the beat counter; the FSM SHALL return to ARB when the transfer has req_lock[owner]=0 or when the counter reaches LOCK_MAX, and ptr<=(owner+1) mod N_REQ.
REQ-025 In LOCKED, a cycle with req_valid[owner]=0 SHALL return to ARB with no transfer, ptr<=(owner+1) mod N_REQ.
REQ-026 On a transfer, register req_addr[g] SHALL load req_data[g]; all other registers SHALL hold their value (enable-gated, no feedback mux required).
REQ-027 wr_en SHALL equal the one-hot of the written address for exactly the cycle after a transfer, else zero; grant_id SHALL update only on transfers.
REQ-028 rd_data SHALL show the pre-edge register value when rd_addr equals a same-cycle write target (no bypass).
REQ-029 req_addr values >= DEPTH (non-power-of-two DEPTH) SHALL be accepted and discarded without changing any register.

Reset
REQ-030 On reset low, the block SHALL asynchronously clear all registers to 0, wr_en to 0, grant_id to 0, ptr to 0, beat counter to 0, state to ARB, and locked to 0.
REQ-031 While reset is low, req_ready SHALL be zero; reset mid-burst SHALL abandon the lock with no partial-beat write.
REQ-032 Reset deassertion SHALL be treated synchronously to clk; the first grant may occur on the first edge after release.

Verification
REQ-033 Round-robin check: all four valid continuously, no lock -> grants 0,1,2,3,0 on consecutive edges; each writes its own address.
REQ-034 Lock check: req 1 valid with lock held continuously, req 2 valid -> req 1 gets 4 beats (locked=1), then req 2 granted next.
REQ-035 Early release check: req 3 locks, then drops req_valid for one cycle -> FSM returns to ARB and req 0 is granted if valid.
REQ-036 Hold check: write 0xA5 to reg 2, then 10 idle cycles -> rd_data at rd_addr=2 stays 0xA5; wr_en=0100 for exactly one cycle.
REQ-037 Reset check: assert reset mid-lock between edges -> all outputs 0 immediately; after release, grant starts from requester 0.
REQ-038 Collision check: reqs 0 and 2 both target reg 1 in successive cycles with 0x11 then 0x22 -> final value is 0x22; wr_en=0010 on two consecutive cycles.
